// File: rtl/param_register_file.sv
// General-purpose register file with R0 hardwired to zero, a per-register busy scoreboard, and a sequential clear engine.
// Optional build macro RF_BYPASS_EN turns on same-cycle write-to-read forwarding.
module param_register_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init_req,
   output logic                       ready,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   output logic                       rsv_ok,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                   state_r;
   state_t                   state_s;
   logic [ADDR_W-1:0]        clr_ptr_r;
   logic [ADDR_W-1:0]        clr_ptr_s;
   logic                     clr_we_s;
   logic [DEPTH-1:0]         busy_r;
   logic [DEPTH-1:0]         busy_s;
   logic [DATA_W-1:0]        regs_r [DEPTH];
   logic                     wr_fire_s;
   logic                     rsv_fire_s;
   logic                     byp_s;
   logic [NUM_RD*DATA_W-1:0] rd_data_s;
   logic [NUM_RD-1:0]        rd_busy_s;

   assign ready = (state_r == ST_READY);

   // init_req in the same cycle as a write or reservation wins and drops them
   assign wr_fire_s  = wr_en  & ready & ~init_req & (wr_addr  != ADDR_W'(0));
   assign rsv_fire_s = rsv_en & ready & ~init_req & (rsv_addr != ADDR_W'(0));
   assign byp_s      = wr_en  & ready & (wr_addr != ADDR_W'(0));

   // Next-state and clear-pointer logic of the clear engine
   always_comb begin
      state_s   = state_r;
      clr_ptr_s = clr_ptr_r;
      clr_we_s  = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            if (init_req) begin
               clr_ptr_s = ADDR_W'(1);
            end else begin
               clr_we_s  = 1'b1;
               clr_ptr_s = clr_ptr_r + ADDR_W'(1);
               if (clr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                  state_s = ST_READY;
               end else begin
                  state_s = ST_CLEAR;
               end
            end
         end
         ST_READY: begin
            if (init_req) begin
               state_s   = ST_CLEAR;
               clr_ptr_s = ADDR_W'(1);
            end else begin
               state_s   = ST_READY;
            end
         end
         default: begin
            state_s   = ST_CLEAR;
            clr_ptr_s = ADDR_W'(1);
         end
      endcase
   end

   // Scoreboard update: writeback clears first so a same-edge reservation ends busy
   always_comb begin
      busy_s = busy_r;
      if (!ready || init_req) begin
         busy_s = '0;
      end else begin
         if (wr_fire_s) begin
            busy_s[wr_addr] = 1'b0;
         end else begin
            busy_s = busy_r;
         end
         if (rsv_fire_s) begin
            busy_s[rsv_addr] = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
      busy_s[0] = 1'b0;
   end

   // Control state, clear pointer and scoreboard registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_CLEAR;
         clr_ptr_r <= ADDR_W'(1);
         busy_r    <= '0;
      end else begin
         state_r   <= state_s;
         clr_ptr_r <= clr_ptr_s;
         busy_r    <= busy_s;
      end
   end

   // Register array; R0 is never written and reads of it are forced to zero
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         regs_r[clr_ptr_r] <= '0;
      end else if (wr_fire_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   // Combinational read ports, blanked while the array is being cleared
   always_comb begin
      rd_data_s = '0;
      rd_busy_s = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!ready || (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(0))) begin
            rd_data_s[i*DATA_W +: DATA_W] = '0;
            rd_busy_s[i]                  = 1'b0;
`ifdef RF_BYPASS_EN
         end else if (byp_s && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data_s[i*DATA_W +: DATA_W] = wr_data;
            rd_busy_s[i]                  = 1'b0;
`endif
         end else begin
            rd_data_s[i*DATA_W +: DATA_W] = regs_r[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy_s[i]                  = busy_r[rd_addr[i*ADDR_W +: ADDR_W]];
         end
      end
   end

   assign rd_data  = rd_data_s;
   assign rd_busy  = rd_busy_s;
   assign rsv_ok   = ready & ~busy_r[rsv_addr];
   assign busy_vec = busy_r;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: table of READY-state vectors plus clear/init/reset sequences.
module tb_param_register_file;

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        init_req;
   logic        ready;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rsv_en;
   logic [2:0]  rsv_addr;
   logic        rsv_ok;
   logic [7:0]  busy_vec;

   int n_cmp = 0;
   int n_err = 0;

   param_register_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) dut (
      .clk(clk), .reset(reset), .init_req(init_req), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [2:0]  wr_addr;
      logic [15:0] wr_data;
      logic        rsv_en;
      logic [2:0]  rsv_addr;
      logic [2:0]  a0;
      logic [2:0]  a1;
      logic [15:0] e0;
      logic [15:0] e1;
      logic [1:0]  eb;
      logic [7:0]  ebv;
      logic        eok;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic re, input logic [2:0] ra,
                               input logic [2:0] a0, input logic [2:0] a1,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input logic [1:0] eb, input logic [7:0] ebv, input logic eok);
      vec_t v;
      v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.rsv_en = re; v.rsv_addr = ra;
      v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv; v.eok = eok;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      init_req = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
      rsv_en = 1'b0; rsv_addr = 3'd0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts 7 clear edges; ready must rise on exactly the last one and reads stay zero before it
   task automatic count_clear(input string tag);
      for (int k = 1; k <= 7; k++) begin
         step();
         chk({tag, "_ready"}, {31'd0, ready}, {31'd0, (k == 7)});
         if (k < 7) chk({tag, "_rd_zero"}, rd_data, 32'h0000_0000);
      end
   endtask

   initial begin
      vecs[0]  = mk(1'b1, 3'd3, 16'hA5A5, 1'b0, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0000, 2'b00, 8'h00, 1'b1);
      vecs[1]  = mk(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 2'b00, 8'h00, 1'b1);
      vecs[2]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd0, 3'd3, 16'h0000, 16'hA5A5, 2'b00, 8'h00, 1'b1);
      vecs[3]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 3'd0, 16'h0000, 16'h0000, 2'b01, 8'h20, 1'b0);
      vecs[4]  = mk(1'b1, 3'd5, 16'h0042, 1'b0, 3'd5, 3'd3, 3'd0, 16'hA5A5, 16'h0000, 2'b00, 8'h20, 1'b0);
      vecs[5]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 3'd5, 3'd5, 16'h0042, 16'h0042, 2'b00, 8'h00, 1'b1);
      vecs[6]  = mk(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 3'd3, 3'd5, 16'hA5A5, 16'h0042, 2'b00, 8'h00, 1'b1);
      vecs[7]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 3'd2, 3'd2, 16'h1111, 16'h1111, 2'b11, 8'h04, 1'b0);
      vecs[8]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 3'd2, 16'h0000, 16'h1111, 2'b10, 8'h04, 1'b1);
      vecs[9]  = mk(1'b1, 3'd4, 16'h1234, 1'b0, 3'd0, 3'd4, 3'd2,
                    BYP ? 16'h1234 : 16'h0000, 16'h1111, 2'b10, 8'h04, 1'b1);
      vecs[10] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd1, 16'h1234, 16'h0000, 2'b00, 8'h04, 1'b1);
      vecs[11] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd2, 16'h1111, 16'h1111, 2'b11, 8'h04, 1'b0);
      vecs[12] = mk(1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd7,
                    BYP ? 16'h2222 : 16'h1111, 16'h0000, BYP ? 2'b00 : 2'b01, 8'h04, 1'b1);
      vecs[13] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd4, 16'h2222, 16'h1234, 2'b00, 8'h00, 1'b1);

      // Reset and the initial clear pass
      idle();
      reset = 1'b1;
      rd_addr = {3'd5, 3'd3};
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy_vec", {24'd0, busy_vec}, 32'd0);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_rsv_ok", {31'd0, rsv_ok}, 32'd0);
      reset = 1'b0;
      count_clear("boot");
      chk("boot_busy_vec", {24'd0, busy_vec}, 32'd0);

      // Table-driven READY-state vectors, outputs checked before the edge of each row
      for (int i = 0; i < 14; i++) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         rsv_en = vecs[i].rsv_en; rsv_addr = vecs[i].rsv_addr;
         rd_addr = {vecs[i].a1, vecs[i].a0};
         #1;
         chk($sformatf("v%0d_rd_data", i), rd_data, {vecs[i].e1, vecs[i].e0});
         chk($sformatf("v%0d_rd_busy", i), {30'd0, rd_busy}, {30'd0, vecs[i].eb});
         chk($sformatf("v%0d_busy_vec", i), {24'd0, busy_vec}, {24'd0, vecs[i].ebv});
         chk($sformatf("v%0d_rsv_ok", i), {31'd0, rsv_ok}, {31'd0, vecs[i].eok});
         step();
      end
      idle();

      // Fill remaining registers, set busy bits, then init_req with a same-cycle write
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0101; step();
      wr_addr = 3'd6; wr_data = 16'h0606; step();
      wr_addr = 3'd7; wr_data = 16'h0707; rsv_en = 1'b1; rsv_addr = 3'd3; step();
      wr_en = 1'b0; rsv_addr = 3'd6; step();
      idle();
      chk("pre_init_busy_vec", {24'd0, busy_vec}, 32'h48);
      rd_addr = {3'd7, 3'd1};
      #1 chk("pre_init_rd_data", rd_data, 32'h0707_0101);
      init_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
      rsv_en = 1'b1; rsv_addr = 3'd1;
      step();
      chk("init_ready", {31'd0, ready}, 32'd0);
      chk("init_busy_vec", {24'd0, busy_vec}, 32'd0);
      // Writes and reservations presented throughout CLEAR must be dropped
      init_req = 1'b0; wr_addr = 3'd3; wr_data = 16'hBEEF; rsv_addr = 3'd2;
      rd_addr = {3'd5, 3'd3};
      count_clear("init");
      idle();
      chk("init_done_busy_vec", {24'd0, busy_vec}, 32'd0);
      for (int a = 0; a < 8; a++) begin
         rd_addr = {a[2:0], a[2:0]};
         #1 chk($sformatf("init_zero_r%0d", a), rd_data, 32'h0);
      end

      // init_req while already clearing restarts the count
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h3333; step();
      idle();
      rd_addr = {3'd0, 3'd3};
      #1 chk("r3_written", rd_data, 32'h0000_3333);
      init_req = 1'b1; step(); init_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("mid_ready", {31'd0, ready}, 32'd0);
      end
      init_req = 1'b1; step(); init_req = 1'b0;
      count_clear("reinit");

      // Asynchronous reset in the middle of a clear pass
      init_req = 1'b1; step(); init_req = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      #1 chk("mid_rst_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      count_clear("rst2");
      #1 chk("final_r3", rd_data, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
